// File: rtl/retire_trace_pkg.sv
// Shared types for the retire trace buffer: the buffered record layout and
// the run-control state encoding.
package retire_trace_pkg;

  localparam int RECORD_W = 103;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        halt;
  } retire_rec_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. The head is read from storage,
// so a pushed word becomes visible on the edge after the push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the push is about to write.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; only the pointers define validity, and an
  // unreset array maps onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Zero the head while empty so stale storage never reaches the outputs.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire-interface trace buffer: FIFOs retired records for a consumer, counts
// cycles and retired instructions, and flags halt or watchdog timeout.
module retire_trace_buffer
  import retire_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 40000,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_retire_valid,
  input  logic [31:0]      i_retire_pc,
  input  logic [31:0]      i_retire_inst,
  input  logic [4:0]       i_retire_rd_waddr,
  input  logic [31:0]      i_retire_rd_wdata,
  input  logic             i_retire_trap,
  input  logic             i_retire_halt,
  output logic             o_trace_valid,
  input  logic             i_trace_ready,
  output logic [31:0]      o_trace_pc,
  output logic [31:0]      o_trace_inst,
  output logic [4:0]       o_trace_rd_waddr,
  output logic [31:0]      o_trace_rd_wdata,
  output logic             o_trace_trap,
  output logic             o_trace_halt,
  output logic [CNT_W-1:0] o_cycles,
  output logic [CNT_W-1:0] o_instret,
  output logic             o_overflow,
  output logic             o_done,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] instret_q;
  logic             overflow_q;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  retire_rec_t      rec_in;
  retire_rec_t      rec_out;

  assign rec_in = '{
    pc:       i_retire_pc,
    inst:     i_retire_inst,
    rd_waddr: i_retire_rd_waddr,
    rd_wdata: i_retire_rd_wdata,
    trap:     i_retire_trap,
    halt:     i_retire_halt
  };

  assign push = i_retire_valid && (state_q == ST_RUN);
  assign pop  = o_trace_valid && i_trace_ready;

  sync_fifo #(
    .WIDTH (RECORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .din   (rec_in),
    .dout  (rec_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every always_comb output gets its default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (i_retire_valid && i_retire_halt) state_d = ST_HALTED;
        else if (cycles_q == TIMEOUT_LAST)   state_d = ST_TIMEOUT;
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      cycles_q   <= '0;
      instret_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RUN) cycles_q <= cycles_q + CNT_W'(1);
      if (push) instret_q <= instret_q + CNT_W'(1);
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign o_trace_valid    = !fifo_empty;
  assign o_trace_pc       = rec_out.pc;
  assign o_trace_inst     = rec_out.inst;
  assign o_trace_rd_waddr = rec_out.rd_waddr;
  assign o_trace_rd_wdata = rec_out.rd_wdata;
  assign o_trace_trap     = rec_out.trap;
  assign o_trace_halt     = rec_out.halt;
  assign o_cycles         = cycles_q;
  assign o_instret        = instret_q;
  assign o_overflow       = overflow_q;
  assign o_done           = (state_q != ST_RUN);
  assign o_timeout        = (state_q == ST_TIMEOUT);

endmodule
